// File: rtl/axis_multich_decimator.sv
// axis_multich_decimator: multi-channel AXI-Stream decimator (pick-last, shifted-sum average or peak)
// keeping one beat per cfg_ratio+1 accepted inputs, with all channels in lockstep.
module axis_multich_decimator #(
    parameter int DATA_IN_WIDTH  = 12,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int NUM_CH         = 2,
    parameter int RATIO_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_enable,
    input  logic [RATIO_WIDTH-1:0]             cfg_ratio,
    input  logic [1:0]                         cfg_mode,
    input  logic [4:0]                         cfg_shift,
    input  logic [NUM_CH*DATA_IN_WIDTH-1:0]    s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    output logic [NUM_CH*DATA_OUT_WIDTH-1:0]   m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tuser
);
    localparam int AW = DATA_IN_WIDTH + RATIO_WIDTH;
    localparam int CW = AW + DATA_OUT_WIDTH;
    localparam logic [1:0] MODE_AVG = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;

    logic [RATIO_WIDTH-1:0]            cnt_q, cnt_d, ratio_q, ratio_d, ratio_e;
    logic [1:0]                        mode_q, mode_d, mode_e;
    logic [4:0]                        shift_q, shift_d, shift_e;
    logic [AW-1:0]                     acc_q [NUM_CH];
    logic [AW-1:0]                     acc_d [NUM_CH];
    logic [AW-1:0]                     acc_n [NUM_CH];
    logic [AW-1:0]                     val;
    logic [DATA_IN_WIDTH-1:0]          smp;
    logic [NUM_CH*DATA_OUT_WIDTH-1:0]  tdata_q, tdata_d, res;
    logic                              tvalid_q, tvalid_d, tuser_q, tuser_d, sat;
    logic                              first, accept, group_end;

    assign s_axis_tready = !cfg_enable | !tvalid_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign first         = cnt_q == '0;
    // The first beat of a group sees the live config; later beats use the shadow copy.
    assign ratio_e       = first ? cfg_ratio : ratio_q;
    assign mode_e        = first ? cfg_mode  : mode_q;
    assign shift_e       = first ? cfg_shift : shift_q;
    assign group_end     = accept & cfg_enable & (cnt_q == ratio_e);

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;

    always_comb begin
        sat = 1'b0;
        res = '0;
        val = '0;
        smp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            smp = s_axis_tdata[c*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            acc_n[c] = first                  ? AW'(smp)
                     : (mode_e == MODE_AVG)   ? acc_q[c] + AW'(smp)
                     : (mode_e == MODE_MAX)   ? ((AW'(smp) > acc_q[c]) ? AW'(smp) : acc_q[c])
                     : AW'(smp);
            val = (mode_e == MODE_AVG) ? acc_n[c] >> shift_e : acc_n[c];
            if (CW'(val) > CW'({DATA_OUT_WIDTH{1'b1}})) begin
                sat = 1'b1;
                res[c*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] = '1;
            end else begin
                res[c*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] = DATA_OUT_WIDTH'(val);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        mode_d   = mode_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q & !m_axis_tready;
        if (!cfg_enable) begin
            cnt_d = '0;
            for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
        end else if (accept) begin
            ratio_d = ratio_e;
            mode_d  = mode_e;
            shift_d = shift_e;
            cnt_d   = group_end ? '0 : cnt_q + RATIO_WIDTH'(1);
            acc_d   = acc_n;
        end
        if (group_end) begin
            tvalid_d = 1'b1;
            tdata_d  = res;
            tuser_d  = sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ratio_q  <= '0;
            mode_q   <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            mode_q   <= mode_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: tb/tb_axis_multich_decimator.sv
// tb_axis_multich_decimator: directed and randomized checks of the decimator against a
// group-list reference model, with a 12-bit-output twin instance for saturation.
module tb_axis_multich_decimator;
    logic        clk;
    logic        rst_n, en, s_tvalid, m_tready;
    logic [15:0] ratio;
    logic [1:0]  mode;
    logic [4:0]  shift;
    logic [23:0] s_tdata;
    logic        s_tready, m_tvalid, m_tuser;
    logic [31:0] m_tdata;
    logic        r12_tready, r12_tvalid, r12_tuser;
    logic [23:0] r12_tdata;

    int passed = 0;
    int total  = 0;
    int hs_cnt = 0;
    logic [31:0] last_data;
    logic        last_user, last_u12;
    logic [23:0] last_d12;

    int unsigned g0[$];
    int unsigned g1[$];
    int          sh_ratio, sh_mode, sh_shift;
    logic [31:0] e_data[$];
    logic        e_user[$];
    logic [23:0] e_d12[$];
    logic        e_u12[$];

    axis_multich_decimator u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(en), .cfg_ratio(ratio), .cfg_mode(mode),
        .cfg_shift(shift), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tuser(m_tuser)
    );

    axis_multich_decimator #(.DATA_OUT_WIDTH(12)) u_d12 (
        .clk(clk), .rst_n(rst_n), .cfg_enable(en), .cfg_ratio(ratio), .cfg_mode(mode),
        .cfg_shift(shift), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(r12_tready), .m_axis_tdata(r12_tdata), .m_axis_tvalid(r12_tvalid),
        .m_axis_tready(m_tready), .m_axis_tuser(r12_tuser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int unsigned reduce(input int unsigned q[$], input int m, input int s);
        int unsigned r = 0;
        if (m == 1) begin
            foreach (q[i]) r += q[i];
            return r >> s;
        end
        if (m == 2) begin
            foreach (q[i]) if (q[i] > r) r = q[i];
            return r;
        end
        return q[q.size()-1];
    endfunction

    function automatic int unsigned clip(input int unsigned v, input int w);
        int unsigned lim = (32'd1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Check one cycle against the model, then advance the model across the coming edge.
    task automatic tick();
        logic        exp_rdy, vld, hs, acc;
        int unsigned r0, r1, a0, a1, b0, b1;
        #1;
        vld     = e_data.size() != 0;
        exp_rdy = !en | !vld | m_tready;
        chk("s_tready", s_tready, exp_rdy);
        chk("s_tready_12", r12_tready, exp_rdy);
        chk("m_tvalid", m_tvalid, vld);
        chk("m_tvalid_12", r12_tvalid, vld);
        if (vld) begin
            chk("m_tdata", m_tdata, e_data[0]);
            chk("m_tuser", m_tuser, e_user[0]);
            chk("m_tdata_12", r12_tdata, e_d12[0]);
            chk("m_tuser_12", r12_tuser, e_u12[0]);
        end
        hs  = vld & m_tready;
        acc = s_tvalid & exp_rdy;
        if (hs) begin
            hs_cnt++;
            last_data = m_tdata;
            last_user = m_tuser;
            last_d12  = r12_tdata;
            last_u12  = r12_tuser;
        end
        if (!rst_n) begin
            g0.delete(); g1.delete();
            e_data.delete(); e_user.delete(); e_d12.delete(); e_u12.delete();
        end else begin
            if (hs) begin
                void'(e_data.pop_front()); void'(e_user.pop_front());
                void'(e_d12.pop_front());  void'(e_u12.pop_front());
            end
            if (!en) begin
                g0.delete(); g1.delete();
            end else if (acc) begin
                if (g0.size() == 0) begin
                    sh_ratio = int'(ratio); sh_mode = int'(mode); sh_shift = int'(shift);
                end
                g0.push_back(s_tdata[11:0]);
                g1.push_back(s_tdata[23:12]);
                if (g0.size() == sh_ratio + 1) begin
                    r0 = reduce(g0, sh_mode, sh_shift);
                    r1 = reduce(g1, sh_mode, sh_shift);
                    a0 = clip(r0, 16); a1 = clip(r1, 16);
                    b0 = clip(r0, 12); b1 = clip(r1, 12);
                    e_data.push_back({a1[15:0], a0[15:0]});
                    e_user.push_back(r0 > 65535 || r1 > 65535);
                    e_d12.push_back({b1[11:0], b0[11:0]});
                    e_u12.push_back(r0 > 4095 || r1 > 4095);
                    g0.delete(); g1.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int a, input int b);
        s_tvalid = 1'b1;
        s_tdata  = {b[11:0], a[11:0]};
        tick();
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int hs0;
        rst_n = 1'b0; en = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        ratio = 16'd0; mode = 2'd0; shift = 5'd0; s_tdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tuser", m_tuser, 1'b0);
        rst_n = 1'b1;

        // PICK, ratio 3, ramp
        ratio = 16'd3; mode = 2'd0;
        for (int n = 0; n < 12; n++) send(n, 100 + n);
        idle(2);
        chk("pick_last_group", last_data, {16'd111, 16'd11});

        // AVG, ratio 3, shift 2, then full-scale sum with shift 0
        mode = 2'd1; shift = 5'd2;
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        idle(2);
        chk("avg_25", last_data, {16'd0, 16'd25});
        shift = 5'd0;
        repeat (4) send(4095, 4095);
        idle(2);
        chk("avg_16380", last_data, {16'd16380, 16'd16380});
        chk("avg_16380_tuser", last_user, 1'b0);
        chk("avg_sat12", last_d12, {12'd4095, 12'd4095});
        chk("avg_sat12_tuser", last_u12, 1'b1);
        ratio = 16'd16;
        repeat (17) send(4095, 1);
        idle(2);
        chk("avg_sat16", last_data, {16'd17, 16'hffff});
        chk("avg_sat16_tuser", last_user, 1'b1);

        // MAX, ratio 4: accumulator must not carry over between groups
        mode = 2'd2; ratio = 16'd4;
        send(5, 5); send(900, 900); send(3, 3); send(899, 899); send(7, 7);
        idle(2);
        chk("max_900", last_data, {16'd900, 16'd900});
        send(1, 1); send(1, 1); send(1, 1); send(1, 1); send(2, 2);
        idle(2);
        chk("max_2", last_data, {16'd2, 16'd2});

        // Pass-through with toggling backpressure
        mode = 2'd0; ratio = 16'd0;
        for (int i = 0; i < 8; i++) begin
            m_tready = (i % 2 == 0);
            send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        end
        m_tready = 1'b1;
        idle(2);

        // Ratio change mid-group waits for the next group
        hs0 = hs_cnt;
        ratio = 16'd3;
        send(1, 1); send(2, 2);
        ratio = 16'd1;
        send(3, 3); send(4, 4); send(5, 5); send(6, 6);
        idle(2);
        chk("ratio_chg_beats", hs_cnt - hs0, 2);
        chk("ratio_chg_last", last_data, {16'd6, 16'd6});

        // Enable drop discards the partial group
        mode = 2'd1; shift = 5'd0; ratio = 16'd3;
        send(100, 100); send(200, 200);
        en = 1'b0;
        send(999, 999);
        en = 1'b1;
        send(1, 1); send(2, 2); send(3, 3); send(4, 4);
        idle(2);
        chk("enable_restart", last_data, {16'd10, 16'd10});

        // Reset with a pending beat, then reset mid-group
        mode = 2'd0; ratio = 16'd0; m_tready = 1'b0;
        send(7, 7);
        rst_n = 1'b0;
        idle(1);
        chk("rst_pend_tvalid", m_tvalid, 1'b0);
        chk("rst_pend_tdata", m_tdata, 32'd0);
        rst_n = 1'b1; m_tready = 1'b1;
        ratio = 16'd3;
        send(8, 8); send(9, 9);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        ratio = 16'd0;
        send(5, 6);
        idle(1);
        chk("rst_mid_restart", last_data, {16'd6, 16'd5});

        // Randomized traffic with config churn
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                ratio = 16'($urandom_range(0, 5));
                mode  = 2'($urandom_range(0, 3));
                shift = 5'($urandom_range(0, 3));
            end
            en       = $urandom_range(0, 30) != 0;
            m_tready = $urandom_range(0, 3) != 0;
            s_tvalid = $urandom_range(0, 3) != 0;
            s_tdata  = 24'($urandom);
            tick();
        end
        en = 1'b1; m_tready = 1'b1;
        idle(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
